// File: rtl/reg_file_dbg_access.sv
// Debug-side initiator for the register file read port 1 and write port.
// Executes READ / WRITE / CLEAR commands while the core is halted and
// returns one response per command. All outputs come straight from flops.
// Optional macro DBG_WRITE_VERIFY_EN: read back each written register and
// report a mismatch in rsp_err.
module reg_file_dbg_access #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halted,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] read_reg1,
    input  logic [DATA_W-1:0] read_data1,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              write_reg_enable
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CLEAR,
`ifdef DBG_WRITE_VERIFY_EN
        S_VERIFY,
`endif
        S_RESP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] counter, counter_n;
    logic              cmd_ready_n, rsp_valid_n, rsp_err_n, we_n;
    logic [DATA_W-1:0] rsp_data_n, write_data_n;
    logic [ADDR_W-1:0] read_reg1_n, write_reg_n;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;

    // Next-state and next-output computation; everything holds unless changed.
    always_comb begin
        state_n      = state;
        counter_n    = counter;
        rsp_valid_n  = rsp_valid;
        rsp_err_n    = rsp_err;
        rsp_data_n   = rsp_data;
        read_reg1_n  = read_reg1;
        write_reg_n  = write_reg;
        write_data_n = write_data;
        we_n         = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!halted || cmd_op == 2'b11) begin
                        state_n     = S_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_data_n  = '0;
                    end else if (cmd_op == 2'b00) begin
                        state_n     = S_READ;
                        read_reg1_n = cmd_addr;
                    end else if (cmd_op == 2'b01) begin
                        if (cmd_addr == '0) begin
                            // x0 is hardwired zero: acknowledge without touching the reg file
                            state_n     = S_RESP;
                            rsp_valid_n = 1'b1;
                            rsp_err_n   = 1'b0;
                            rsp_data_n  = '0;
                        end else begin
                            state_n      = S_WRITE;
                            write_reg_n  = cmd_addr;
                            write_data_n = cmd_wdata;
                            we_n         = 1'b1;
                        end
                    end else begin
                        state_n      = S_CLEAR;
                        counter_n    = ADDR_W'(1);
                        write_reg_n  = ADDR_W'(1);
                        write_data_n = '0;
                        we_n         = 1'b1;
                    end
                end
            end
            S_READ: begin
                state_n     = S_RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = read_data1;
            end
            S_WRITE: begin
`ifdef DBG_WRITE_VERIFY_EN
                // write commits at the end of this cycle; read it back next cycle
                state_n     = S_VERIFY;
                read_reg1_n = write_reg;
`else
                state_n     = S_RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = write_data;
`endif
            end
`ifdef DBG_WRITE_VERIFY_EN
            S_VERIFY: begin
                state_n     = S_RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = (read_data1 != write_data);
                rsp_data_n  = read_data1;
            end
`endif
            S_CLEAR: begin
                // counter = register being written this cycle = writes done at the edge
                if (counter == LAST_REG) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_data_n  = DATA_W'(counter);
                end else if (!halted) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_data_n  = DATA_W'(counter);
                end else begin
                    counter_n   = counter + ADDR_W'(1);
                    write_reg_n = counter + ADDR_W'(1);
                    we_n        = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n     = S_IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
        cmd_ready_n = (state_n == S_IDLE);
    end

    // State and output registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            counter          <= '0;
            cmd_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_err          <= 1'b0;
            rsp_data         <= '0;
            read_reg1        <= '0;
            write_reg        <= '0;
            write_data       <= '0;
            write_reg_enable <= 1'b0;
        end else begin
            state            <= state_n;
            counter          <= counter_n;
            cmd_ready        <= cmd_ready_n;
            rsp_valid        <= rsp_valid_n;
            rsp_err          <= rsp_err_n;
            rsp_data         <= rsp_data_n;
            read_reg1        <= read_reg1_n;
            write_reg        <= write_reg_n;
            write_data       <= write_data_n;
            write_reg_enable <= we_n;
        end
    end

endmodule

// File: tb/tb_reg_file_dbg_access.sv
// Scoreboard bench for reg_file_dbg_access with a behavioural reg file.
module tb_reg_file_dbg_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  read_reg1;
    logic [31:0] read_data1;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        write_reg_enable;

`ifdef DBG_WRITE_VERIFY_EN
    localparam int WR_LAT = 2;
`else
    localparam int WR_LAT = 1;
`endif

    reg_file_dbg_access dut (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .read_reg1(read_reg1), .read_data1(read_data1),
        .write_reg(write_reg), .write_data(write_data), .write_reg_enable(write_reg_enable)
    );

    always #5 clk = ~clk;

    // behavioural reg file: combinational read, x0 reads zero
    logic [31:0] regs [32] = '{default: 32'h0};
    assign read_data1 = (read_reg1 == 5'd0) ? 32'h0 : regs[read_reg1];
    always @(posedge clk) if (write_reg_enable && write_reg != 5'd0) regs[write_reg] <= write_data;

    typedef struct { logic [31:0] data; logic err; longint t_acc; int lat; } exp_t;
    typedef struct { logic [4:0] a; logic [31:0] d; longint t; } wr_t;
    exp_t sbq[$];
    wr_t  wlog[$];
    int   total = 0;
    int   bad = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // record every write-enable cycle
    always @(negedge clk) begin
        wr_t w;
        if (write_reg_enable) begin
            w.a = write_reg; w.d = write_data; w.t = $time;
            wlog.push_back(w);
        end
    end

    // response monitor: latency on rising rsp_valid, data/err on handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && !prev_valid && sbq.size() != 0 && sbq[0].lat >= 0)
            chk("latency", 64'(($time - sbq[0].t_acc - 5) / 10), 64'(sbq[0].lat));
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) chk("unexpected_rsp", {rsp_err, rsp_data}, 64'h0);
            else begin
                e = sbq.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input int lat, input bit push);
        exp_t e;
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            chk("cmd_ready_timeout", 64'(cmd_ready), 64'h1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.data = ed; e.err = ee; e.t_acc = $time; e.lat = lat;
        if (push) sbq.push_back(e);
        #1;
        // scramble to show the command was latched at accept
        cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~wd;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || rsp_valid) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("idle_timeout", 64'(sbq.size()), 64'h0);
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        // reset state
        #12;
        chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_data, read_reg1, write_reg, write_reg_enable},
            64'h0);
        chk("reset_wdata", write_data, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 64'h1);

        // WRITE x5
        wlog.delete();
        send(2'b01, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, WR_LAT, 1);
        wait_idle();
        chk("write_pulse_count", 64'(wlog.size()), 64'h1);
        if (wlog.size() > 0) chk("write_pulse", {wlog[0].a, wlog[0].d}, {5'd5, 32'hDEADBEEF});

        // READ x5
        send(2'b00, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1);
        wait_idle();
        chk("read_reg1", read_reg1, 64'd5);

        // WRITE x0: no enable
        wlog.delete();
        send(2'b01, 5'd0, 32'h1234, 32'h0, 1'b0, 0, 1);
        wait_idle();
        chk("x0_no_write", 64'(wlog.size()), 64'h0);

        // full CLEAR
        send(2'b01, 5'd7, 32'h77, 32'h77, 1'b0, WR_LAT, 1); wait_idle();
        send(2'b01, 5'd31, 32'h31, 32'h31, 1'b0, WR_LAT, 1); wait_idle();
        wlog.delete();
        send(2'b10, 5'd0, 32'h0, 32'd31, 1'b0, 31, 1);
        wait_idle();
        ok = 1'b1;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i].a != 5'(i + 1) || wlog[i].d != 32'h0 || (i > 0 && wlog[i].t != wlog[i-1].t + 10)) ok = 1'b0;
        chk("clear_sweep", {32'(wlog.size()), 31'h0, ok}, {32'd31, 31'h0, 1'b1});
        send(2'b00, 5'd7, 32'h0, 32'h0, 1'b0, 1, 1);
        wait_idle();

        // CLEAR aborted by halted falling during the x9 write cycle
        send(2'b01, 5'd10, 32'hA5, 32'hA5, 1'b0, WR_LAT, 1); wait_idle();
        wlog.delete();
        send(2'b10, 5'd0, 32'h0, 32'd9, 1'b1, 9, 1);
        repeat (8) @(posedge clk);
        #2 halted = 1'b0;
        wait_idle();
        halted = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < wlog.size(); i++) if (wlog[i].a != 5'(i + 1)) ok = 1'b0;
        chk("partial_clear", {32'(wlog.size()), 31'h0, ok}, {32'd9, 31'h0, 1'b1});
        send(2'b00, 5'd10, 32'h0, 32'hA5, 1'b0, 1, 1);
        wait_idle();

        // not halted READ, then illegal op with backpressure
        wlog.delete();
        halted = 1'b0;
        send(2'b00, 5'd5, 32'h0, 32'h0, 1'b1, 0, 1);
        wait_idle();
        halted = 1'b1;
        rsp_ready = 1'b0;
        send(2'b11, 5'd5, 32'h55, 32'h0, 1'b1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp", {cmd_ready, rsp_valid, rsp_err, rsp_data}, {1'b0, 1'b1, 1'b1, 32'h0});
        end
        rsp_ready = 1'b1;
        wait_idle();
        chk("err_no_access", 64'(wlog.size()), 64'h0);

        // reset in the middle of a CLEAR
        send(2'b10, 5'd0, 32'h0, 32'h0, 1'b0, -1, 0);
        repeat (3) @(posedge clk);
        #2 chk("mid_clear_we", write_reg_enable, 64'h1);
        rst_n = 1'b0;
        #1 chk("async_we_drop", {write_reg_enable, rsp_valid}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {cmd_ready, rsp_valid, write_reg_enable}, {1'b1, 1'b0, 1'b0});

        // normal operation resumes
        send(2'b01, 5'd3, 32'h3333, 32'h3333, 1'b0, WR_LAT, 1); wait_idle();
        send(2'b00, 5'd3, 32'h0, 32'h3333, 1'b0, 1, 1); wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

endmodule
